// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths, ID/EXE control struct and bubble helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RADDR_W = 5;
  localparam int DEF_ALUOP_W = 2;

  typedef struct packed {
    logic                   valid;
    logic                   wreg;
    logic                   m2reg;
    logic                   wmem;
    logic                   aluimm;
    logic [DEF_ALUOP_W-1:0] aluop;
  } id_exe_ctrl_t;

  localparam id_exe_ctrl_t CTRL_BUBBLE = '0;

  // A bubble kills every side-effecting bit; operand-related fields are left alone.
  function automatic id_exe_ctrl_t make_bubble(input id_exe_ctrl_t c);
    id_exe_ctrl_t b;
    b       = c;
    b.valid = 1'b0;
    b.wreg  = 1'b0;
    b.m2reg = 1'b0;
    b.wmem  = 1'b0;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_exe_stage_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_stage_reg_if
// Description : Decode-to-execute bundle; master = decode side, slave = stage reg.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_exe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int ALUOP_W = DEF_ALUOP_W
) ();

  logic               id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm;
  logic [ALUOP_W-1:0] id_aluop;
  logic [RADDR_W-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0]  id_qa, id_qb, id_imm;

  logic               ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm;
  logic [ALUOP_W-1:0] ex_aluop;
  logic [RADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0]  ex_qa, ex_qb, ex_imm;

  modport master (
    output id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_aluop,
           id_rs, id_rt, id_rd, id_qa, id_qb, id_imm,
    input  ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluop,
           ex_rd, ex_qa, ex_qb, ex_imm
  );

  modport slave (
    input  id_valid, id_wreg, id_m2reg, id_wmem, id_aluimm, id_aluop,
           id_rs, id_rt, id_rd, id_qa, id_qb, id_imm,
    output ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm, ex_aluop,
           ex_rd, ex_qa, ex_qb, ex_imm
  );

endinterface
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Load-use hazard detect between the EXE load and the decode sources.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int RADDR_W = DEF_RADDR_W
) (
  input  logic               i_ex_valid,
  input  logic               i_ex_wreg,
  input  logic               i_ex_m2reg,
  input  logic [RADDR_W-1:0] i_ex_rd,
  input  logic               i_id_valid,
  input  logic [RADDR_W-1:0] i_id_rs,
  input  logic [RADDR_W-1:0] i_id_rt,
  output logic               o_load_use
);

  logic w_addr_hit;

  // Register zero is never a real producer, so it cannot create a dependency.
  assign w_addr_hit = (i_ex_rd != '0) && ((i_ex_rd == i_id_rs) || (i_ex_rd == i_id_rt));
  assign o_load_use = i_ex_valid & i_ex_m2reg & i_ex_wreg & i_id_valid & w_addr_hit;

endmodule
`default_nettype wire

// File: rtl/id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : id_exe_stage_reg
// Description : ID/EXE pipeline register with hold, flush, load-use bubbles and bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_exe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int ALUOP_W = DEF_ALUOP_W,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             exe_hold,
  input  logic             flush,
  id_exe_stage_reg_if.slave bus,
  output logic             id_stall,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  id_exe_ctrl_t       r_ctrl;
  id_exe_ctrl_t       w_id_ctrl;
  logic [RADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]  r_qa, r_qb, r_imm;
  logic [CNT_W-1:0]   r_bubble_cnt;
  logic               w_load_use;

  hazard_unit #(.RADDR_W(RADDR_W)) u_hazard (
    .i_ex_valid (r_ctrl.valid),
    .i_ex_wreg  (r_ctrl.wreg),
    .i_ex_m2reg (r_ctrl.m2reg),
    .i_ex_rd    (r_rd),
    .i_id_valid (bus.id_valid),
    .i_id_rs    (bus.id_rs),
    .i_id_rt    (bus.id_rt),
    .o_load_use (w_load_use)
  );

  // A non-valid instruction may still carry write enables; mask them on entry.
  always_comb begin
    w_id_ctrl        = CTRL_BUBBLE;
    w_id_ctrl.valid  = bus.id_valid;
    w_id_ctrl.wreg   = bus.id_wreg & bus.id_valid;
    w_id_ctrl.m2reg  = bus.id_m2reg;
    w_id_ctrl.wmem   = bus.id_wmem & bus.id_valid;
    w_id_ctrl.aluimm = bus.id_aluimm;
    w_id_ctrl.aluop  = DEF_ALUOP_W'(bus.id_aluop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctrl       <= CTRL_BUBBLE;
      r_rd         <= '0;
      r_qa         <= '0;
      r_qb         <= '0;
      r_imm        <= '0;
      r_bubble_cnt <= '0;
    end else if (flush) begin
      r_ctrl <= make_bubble(r_ctrl);
    end else if (exe_hold) begin
      r_ctrl <= r_ctrl;
    end else if (w_load_use) begin
      r_ctrl <= make_bubble(r_ctrl);
      if (r_bubble_cnt != C_CNT_MAX) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end else begin
      r_ctrl <= w_id_ctrl;
      r_rd   <= bus.id_rd;
      r_qa   <= bus.id_qa;
      r_qb   <= bus.id_qb;
      r_imm  <= bus.id_imm;
    end
  end

  assign id_stall      = w_load_use | exe_hold;
  assign bubble_cnt    = r_bubble_cnt;

  assign bus.ex_valid  = r_ctrl.valid;
  assign bus.ex_wreg   = r_ctrl.wreg;
  assign bus.ex_m2reg  = r_ctrl.m2reg;
  assign bus.ex_wmem   = r_ctrl.wmem;
  assign bus.ex_aluimm = r_ctrl.aluimm;
  assign bus.ex_aluop  = ALUOP_W'(r_ctrl.aluop);
  assign bus.ex_rd     = r_rd;
  assign bus.ex_qa     = r_qa;
  assign bus.ex_qb     = r_qb;
  assign bus.ex_imm    = r_imm;

endmodule
`default_nettype wire

// File: tb/tb_id_exe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_exe_stage_reg
// Description : Directed scoreboard bench for id_exe_stage_reg (counter width 2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_exe_stage_reg;

  localparam int CNT_W = 2;

  typedef struct {
    logic        v, w, m, wm, ai;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] qa, qb, imm;
    logic [1:0]  cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             resetn;
  logic             exe_hold;
  logic             flush;
  logic             id_stall;
  logic [CNT_W-1:0] bubble_cnt;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t mdl;

  id_exe_stage_reg_if bus ();

  id_exe_stage_reg #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .exe_hold   (exe_hold),
    .flush      (flush),
    .bus        (bus),
    .id_stall   (id_stall),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one decode instruction, check the combinational stall, push the next-state expectation.
  task automatic drive(input logic v, input logic w, input logic m, input logic wm, input logic ai,
                       input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] qa, input logic [31:0] qb,
                       input logic [31:0] imm, input logic h, input logic f);
    logic lu;
    bus.id_valid = v;  bus.id_wreg = w;  bus.id_m2reg = m; bus.id_wmem = wm;
    bus.id_aluimm = ai; bus.id_aluop = op; bus.id_rs = rs; bus.id_rt = rt;
    bus.id_rd = rd;    bus.id_qa = qa;   bus.id_qb = qb;   bus.id_imm = imm;
    exe_hold = h; flush = f;
    #1;
    lu = mdl.v & mdl.m & mdl.w & v & (mdl.rd != 5'd0) & ((mdl.rd == rs) | (mdl.rd == rt));
    chk("id_stall", id_stall, lu | h);
    if (f) begin
      mdl.v = 0; mdl.w = 0; mdl.m = 0; mdl.wm = 0;
    end else if (h) begin
      mdl = mdl;
    end else if (lu) begin
      mdl.v = 0; mdl.w = 0; mdl.m = 0; mdl.wm = 0;
      if (mdl.cnt != 2'd3) mdl.cnt = mdl.cnt + 2'd1;
    end else begin
      mdl.v = v; mdl.w = w & v; mdl.m = m; mdl.wm = wm & v; mdl.ai = ai;
      mdl.op = op; mdl.rd = rd; mdl.qa = qa; mdl.qb = qb; mdl.imm = imm;
    end
    sb.push_back(mdl);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk("ex_valid", bus.ex_valid, e.v);
      chk("ex_wreg", bus.ex_wreg, e.w);
      chk("ex_m2reg", bus.ex_m2reg, e.m);
      chk("ex_wmem", bus.ex_wmem, e.wm);
      chk("bubble_cnt", bubble_cnt, e.cnt);
      if (e.v) begin
        chk("ex_aluimm", bus.ex_aluimm, e.ai);
        chk("ex_aluop", bus.ex_aluop, e.op);
        chk("ex_rd", bus.ex_rd, e.rd);
        chk("ex_qa", bus.ex_qa, e.qa);
        chk("ex_qb", bus.ex_qb, e.qb);
        chk("ex_imm", bus.ex_imm, e.imm);
      end
    end
  endtask

  // Assert reset away from any clock edge and verify it acts without one.
  task automatic do_reset();
    @(negedge clk);
    #2;
    exe_hold = 1'($urandom_range(0, 1));
    resetn = 1'b0;
    #1;
    chk("rst_ex_valid", bus.ex_valid, 1'b0);
    chk("rst_ctrl", {bus.ex_wreg, bus.ex_m2reg, bus.ex_wmem, bus.ex_aluimm, bus.ex_aluop}, 6'd0);
    chk("rst_rd", bus.ex_rd, 5'd0);
    chk("rst_data", {bus.ex_qa, bus.ex_qb}, 64'd0);
    chk("rst_imm", bus.ex_imm, 32'd0);
    chk("rst_bubble_cnt", bubble_cnt, 2'd0);
    chk("rst_id_stall", id_stall, exe_hold);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    mdl = '{v: 0, w: 0, m: 0, wm: 0, ai: 0, op: 0, rd: 0, qa: 0, qb: 0, imm: 0, cnt: 0};
    sb.delete();
  endtask

  initial begin
    resetn = 1'b1; exe_hold = 1'b0; flush = 1'b0;
    bus.id_valid = 1'b1; bus.id_wreg = 1'($urandom); bus.id_m2reg = 1'($urandom);
    bus.id_wmem = 1'($urandom); bus.id_aluimm = 1'($urandom); bus.id_aluop = 2'($urandom);
    bus.id_rs = 5'($urandom); bus.id_rt = 5'($urandom); bus.id_rd = 5'($urandom);
    bus.id_qa = $urandom; bus.id_qb = $urandom; bus.id_imm = $urandom;
    repeat (2) @(posedge clk);

    // Asynchronous reset, then plain one-cycle load
    do_reset();
    drive(1, 1, 0, 0, 0, 2'd1, 5'd3, 5'd4, 5'd9, 32'h1234_5678, 32'h0000_00AA, 32'hFFFF_FFF0, 0, 0);
    tick();
    chk("load_qa", bus.ex_qa, 32'h1234_5678);
    chk("load_rd", bus.ex_rd, 5'd9);

    // Load-use on r8: one bubble, then the held instruction loads
    drive(1, 1, 1, 0, 1, 2'd0, 5'd1, 5'd2, 5'd8, 32'h0000_1000, 32'h0, 32'h4, 0, 0);
    tick();
    drive(1, 1, 0, 0, 0, 2'd2, 5'd8, 5'd5, 5'd10, 32'hDEAD_BEEF, 32'h5, 32'h0, 0, 0);
    chk("lu_stall_direct", id_stall, 1'b1);
    tick();
    chk("lu_bubble_cnt", bubble_cnt, 2'd1);
    drive(1, 1, 0, 0, 0, 2'd2, 5'd8, 5'd5, 5'd10, 32'hDEAD_BEEF, 32'h5, 32'h0, 0, 0);
    tick();

    // Load to r0 never stalls
    drive(1, 1, 1, 0, 0, 2'd0, 5'd6, 5'd7, 5'd0, 32'h1, 32'h2, 32'h3, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 2'd3, 5'd0, 5'd0, 5'd11, 32'h4, 32'h5, 32'h6, 0, 0);
    chk("r0_no_stall", id_stall, 1'b0);
    tick();

    // Three held cycles with changing decode inputs
    drive(1, 1, 0, 0, 1, 2'd1, 5'd1, 5'd2, 5'd12, 32'hCAFE_0001, 32'h7, 32'h8, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 1, 0, 2'(i), 5'd20, 5'd21, 5'(13 + i), 32'(i * 3 + 100), 32'(i), 32'(~i), 1, 0);
      tick();
    end

    // Flush beats hold and an active load-use hazard
    drive(1, 1, 1, 0, 0, 2'd0, 5'd1, 5'd2, 5'd8, 32'h10, 32'h0, 32'h0, 0, 0);
    tick();
    drive(1, 1, 0, 1, 0, 2'd2, 5'd8, 5'd8, 5'd14, 32'h20, 32'h21, 32'h22, 1, 1);
    tick();
    chk("flush_valid", bus.ex_valid, 1'b0);

    // Non-valid instruction loads with its write enables masked
    drive(0, 1, 1, 1, 1, 2'd3, 5'd0, 5'd0, 5'd15, 32'h30, 32'h31, 32'h32, 0, 0);
    tick();
    drive(1, 0, 0, 1, 1, 2'd3, 5'd0, 5'd0, 5'd16, 32'h40, 32'h41, 32'h42, 0, 0);
    tick();

    // Saturation: lw r8,[r8] repeated gives a bubble every other edge
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 1, 0, 1, 2'd0, 5'd8, 5'd8, 5'd8, 32'h100, 32'h0, 32'h4, 0, 0);
      tick();
      if (i % 2 == 1) chk("sat_seq", bubble_cnt, (i / 2 + 1 > 3) ? 2'd3 : 2'((i / 2) + 1));
    end

    exe_hold = 1'b0; flush = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/id_exe_stage_reg.md
# id_exe_stage_reg

Parametrised ID/EXE pipeline stage register for the pipelined MIPS core, placed between the decode stage (register file, sign-extender, destination mux) and the execute stage (ALU operand mux, ALU). It adds several things a plain clocked register lacks: a valid bit, asynchronous reset, a downstream hold, a branch flush, built-in load-use hazard detection with bubble insertion, and a saturating bubble counter for performance monitoring.

## Interface
- DATA_W, 32, width of qa, qb and sign-extended immediate
- RADDR_W, 5, register-address width (rs, rt, destination)
- ALUOP_W, 2, ALU operation code width
- CNT_W, 16, bubble-counter width
- clk  in  1  pipeline clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a real instruction
- id_wreg, id_m2reg, id_wmem, id_aluimm  in  1 each  decode control bits
- id_aluop  in  ALUOP_W  ALU operation
- id_rs, id_rt  in  RADDR_W  source register numbers of the instruction in decode
- id_rd  in  RADDR_W  selected destination register
- id_qa, id_qb, id_imm  in  DATA_W  operands and sign-extended immediate
- exe_hold  in  1  execute stage cannot accept; freeze register
- flush  in  1  kill instruction entering EXE (taken branch/jump)
- ex_valid, ex_wreg, ex_m2reg, ex_wmem, ex_aluimm  out  1 each  registered controls
- ex_aluop  out  ALUOP_W; ex_rd  out  RADDR_W
- ex_qa, ex_qb, ex_imm  out  DATA_W
- id_stall  out  1  combinational; decode and fetch must hold their registers this cycle
- bubble_cnt  out  CNT_W  number of hazard bubbles inserted, saturating

## Operation
- Hazard (combinational):
  - load_use = ex_valid & ex_m2reg & ex_wreg & id_valid & (ex_rd != 0) & (ex_rd == id_rs | ex_rd == id_rt).
  - id_stall = load_use | exe_hold.
- Next-state priority on each rising edge:
  1. flush
  2. exe_hold
  3. load_use
  4. load
- flush: inserts a bubble. Applies even while exe_hold is high.
- exe_hold (no flush): every output register keeps its value.
- load_use (no flush, no hold): inserts a bubble.
- load: all ex_* registers take the corresponding id_* values, with ex_valid = id_valid.
- Bubble definition:
  - ex_valid, ex_wreg, ex_m2reg and ex_wmem are cleared to 0.
  - ex_aluimm, ex_aluop, ex_rd, ex_qa, ex_qb and ex_imm keep their previous values. These are don't-care downstream; the bench does not check them when ex_valid = 0.
- Loading a non-valid instruction (id_valid = 0): the register loads it normally, but ex_wreg and ex_wmem are forced to 0 so that no side effect can escape.
- bubble_cnt:
  - Increments by 1 on each edge where a load_use bubble is inserted, i.e. case 3 is actually selected.
  - Flush bubbles and held cycles do not count.
  - Saturates at 2^CNT_W − 1; never wraps.

## Timing
- Latency is one cycle when there is no hold, flush or hazard: id_* at edge N appears on ex_* after edge N.
- A load-use hazard costs exactly one bubble. After the bubble, ex_m2reg = 0, so load_use drops and the held decode instruction loads on the next edge.
- id_stall is combinational from the current ex_* registers and id_rs/id_rt/id_valid/exe_hold. There is no registered delay.
- resetn low (asynchronous, takes effect immediately, independent of clk):
  - All outputs go to 0: ex_valid = 0, all controls 0, ex_aluop = 0, ex_rd = 0, ex_qa/qb/imm = 0, bubble_cnt = 0.
  - id_stall evaluates to exe_hold.
- Reset release takes effect at the first clk edge with resetn high. Reset asserted during a hazard or hold discards the state; no bubble is counted for that edge.
- Simultaneous flush and load_use: a flush bubble is inserted and bubble_cnt does not increment.

## Structure
- Shared package pipe_pkg, holding:
  - the default widths (DATA_W, RADDR_W, ALUOP_W);
  - a packed struct id_exe_ctrl_t {valid, wreg, m2reg, wmem, aluimm, aluop};
  - the constant CTRL_BUBBLE, with all control bits 0.
- One sub-module, hazard_unit, which computes load_use from the ex_* and id_* address and control signals. It is reused later for forwarding. The register and counter stay in the top module.

## Test plan
- Reset: drive resetn low mid-cycle with random inputs -> all outputs are 0 immediately. Release, then load id_qa = 32'h1234_5678, id_rd = 5'd9, id_wreg = 1 -> one edge later ex_qa = 32'h1234_5678, ex_rd = 9, ex_valid = 1.
- Load-use: load lw with ex_rd = 8, ex_m2reg = ex_wreg = 1; the next decode has id_rs = 8 -> id_stall = 1 that cycle, the next edge gives ex_valid = 0 and bubble_cnt = 1, and the following edge loads the held instruction.
- Register zero: same as the load-use case but with ex_rd = 0 and id_rs = 0 -> id_stall = 0, no bubble, bubble_cnt unchanged.
- Hold: assert exe_hold for 3 cycles with changing id_* -> ex_* is frozen for all 3 cycles, id_stall = 1 throughout, bubble_cnt unchanged.
- Flush: flush together with an active load-use hazard and exe_hold = 1 -> ex_valid = 0, ex_wreg = ex_wmem = 0, bubble_cnt unchanged.
- Saturation: with CNT_W = 2, force 5 consecutive hazard bubbles -> bubble_cnt sequence is 1, 2, 3, 3, 3.
